// File: rtl/pi_duty_ctrl_pkg.sv
// Shared types, limits and saturation helpers for the PI duty-cycle regulator.
package pi_duty_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_INTEG   = 3'd2,
        ST_SUM     = 3'd3,
        ST_UPDATE  = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam int DATA_W  = 12;
    localparam int DUTY_W  = 11;
    localparam int ERR_W   = 12;
    localparam int INTEG_W = 16;
    localparam int ERR_MAX = 2047;

    localparam logic [DUTY_W-1:0] DUTY_MIN = 11'd0;
    // 64 + DUTY_MAX + 128 stays within 11 bits, so blanking windows never wrap.
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'd1855;

    localparam logic signed [12:0] ERR_HI     = 13'sd2047;
    localparam logic signed [12:0] ERR_LO     = -13'sd2047;
    localparam logic signed [16:0] INTEG_HI   = 17'sd32767;
    localparam logic signed [16:0] INTEG_LO   = -17'sd32768;
    localparam logic signed [16:0] DUTY_MIN_S = 17'sd0;
    localparam logic signed [16:0] DUTY_MAX_S = 17'sd1855;

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [12:0] d);
        if (d > ERR_HI) begin
            return 12'sd2047;
        end else if (d < ERR_LO) begin
            return -12'sd2047;
        end else begin
            return d[ERR_W-1:0];
        end
    endfunction

    function automatic logic signed [INTEG_W-1:0] sat_integ(input logic signed [16:0] v);
        if (v > INTEG_HI) begin
            return 16'sh7FFF;
        end else if (v < INTEG_LO) begin
            return 16'sh8000;
        end else begin
            return v[INTEG_W-1:0];
        end
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [16:0] v);
        if (v < DUTY_MIN_S) begin
            return DUTY_MIN;
        end else if (v > DUTY_MAX_S) begin
            return DUTY_MAX;
        end else begin
            return v[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pi_duty_ctrl_if.sv
// Control/measurement bundle between the PWM controller and the PI regulator.
interface pi_duty_ctrl_if;
    logic        en;
    logic        PWM_synch;
    logic        ovr_I_blank;
    logic        ovr_I;
    logic [11:0] setpoint;
    logic [11:0] meas;
    logic        clr_fault;
    logic [10:0] duty;
    logic        duty_vld;
    logic        fault;

    modport master (
        output en, PWM_synch, ovr_I_blank, ovr_I, setpoint, meas, clr_fault,
        input  duty, duty_vld, fault
    );

    modport slave (
        input  en, PWM_synch, ovr_I_blank, ovr_I, setpoint, meas, clr_fault,
        output duty, duty_vld, fault
    );
endinterface

// File: rtl/pi_duty_ctrl_ovr_i_mon.sv
// Over-current monitor: per-PWM-period flag, two-consecutive-period trip and fault latch.
module ovr_i_mon (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm_synch,
    input  logic i_ovr_i,
    input  logic i_ovr_i_blank,
    input  logic i_clr_fault,
    output logic o_trip,
    output logic o_fault
);
    logic r_flag;
    logic r_prev;
    logic r_fault;
    logic w_flag_now;

    // The period ending on this PWM_synch includes the synch cycle itself.
    assign w_flag_now = r_flag | (i_ovr_i & ~i_ovr_i_blank);
    assign o_trip     = i_pwm_synch & w_flag_now & r_prev;
    assign o_fault    = r_fault;

    // Period flag, previous-period flag and latched fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag  <= 1'b0;
            r_prev  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (i_pwm_synch) begin
                r_flag <= 1'b0;
                r_prev <= w_flag_now;
            end else begin
                r_flag <= w_flag_now;
            end
            if (o_trip) begin
                r_fault <= 1'b1;
            end else if (i_clr_fault) begin
                r_fault <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pi_duty_ctrl.sv
// PI duty-cycle regulator, one update per PWM period, 4-clock pipeline.
// Optional over-current shutdown compiled in with OVR_I_SHUTDOWN_EN.
module pi_duty_ctrl
    import pi_duty_ctrl_pkg::*;
#(
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pi_duty_ctrl_if.slave  bus
);
    state_t                     r_state;
    logic [DATA_W-1:0]          r_sp;
    logic [DATA_W-1:0]          r_meas;
    logic signed [ERR_W-1:0]    r_err;
    logic signed [INTEG_W-1:0]  r_integ;
    logic [DUTY_W-1:0]          r_s;
    logic [DUTY_W-1:0]          r_duty;
    logic                       r_duty_vld;

    logic signed [12:0]         w_diff;
    logic signed [INTEG_W-1:0]  w_integ_next;
    logic signed [16:0]         w_p;
    logic signed [16:0]         w_i;
    logic                       w_trip;
    logic                       w_fault;

    assign w_diff       = $signed({1'b0, r_sp}) - $signed({1'b0, r_meas});
    assign w_integ_next = sat_integ(17'(r_integ) + 17'(r_err));
    assign w_p          = 17'(r_err >>> KP_SHIFT);
    assign w_i          = 17'(r_integ >>> KI_SHIFT);

`ifdef OVR_I_SHUTDOWN_EN
    ovr_i_mon u_ovr_i_mon (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pwm_synch   (bus.PWM_synch),
        .i_ovr_i       (bus.ovr_I),
        .i_ovr_i_blank (bus.ovr_I_blank),
        .i_clr_fault   (bus.clr_fault),
        .o_trip        (w_trip),
        .o_fault       (w_fault)
    );
`else
    logic w_unused_ovr;
    assign w_unused_ovr = bus.ovr_I ^ bus.ovr_I_blank;
    assign w_trip       = 1'b0;
    assign w_fault      = 1'b0;
`endif

    assign bus.duty     = r_duty;
    assign bus.duty_vld = r_duty_vld;
    assign bus.fault    = w_fault;

    // Regulator FSM; a fault trip outranks en, which outranks the normal sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sp       <= 12'd0;
            r_meas     <= 12'd0;
            r_err      <= 12'sd0;
            r_integ    <= 16'sd0;
            r_s        <= 11'd0;
            r_duty     <= 11'd0;
            r_duty_vld <= 1'b0;
        end else begin
            r_duty_vld <= 1'b0;
            if (w_trip) begin
                r_state    <= ST_FAULT;
                r_duty     <= DUTY_MIN;
                r_integ    <= 16'sd0;
                r_duty_vld <= (r_duty != DUTY_MIN);
            end else if ((r_state != ST_FAULT) && !bus.en) begin
                r_state <= ST_IDLE;
                r_duty  <= DUTY_MIN;
                r_integ <= 16'sd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.PWM_synch && !w_fault) begin
                            r_sp    <= bus.setpoint;
                            r_meas  <= bus.meas;
                            r_state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        r_err   <= sat_err(w_diff);
                        r_state <= ST_INTEG;
                    end
                    ST_INTEG: begin
                        r_integ <= w_integ_next;
                        r_state <= ST_SUM;
                    end
                    ST_SUM: begin
                        r_s     <= clamp_duty(w_p + w_i);
                        r_state <= ST_UPDATE;
                    end
                    ST_UPDATE: begin
                        r_duty     <= r_s;
                        r_duty_vld <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                    ST_FAULT: begin
                        if (bus.clr_fault) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/pi_duty_ctrl.md
PI_DUTY_CTRL -- requirements
Module: pi_duty_ctrl

Interface
REQ-001 Parameter KP_SHIFT, default 2: proportional term is err arithmetically shifted right by KP_SHIFT.
REQ-002 Parameter KI_SHIFT, default 4: integral term is integ arithmetically shifted right by KI_SHIFT.
REQ-003 clk  input  1  one clock (50 MHz); all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 en  input  1  regulator enable; low forces idle.
REQ-006 PWM_synch  input  1  one-cycle pulse at PWM counter wrap; starts each update.
REQ-007 ovr_I_blank  input  1  high = over-current comparator ignored.
REQ-008 ovr_I  input  1  raw over-current comparator, already synchronous to clk.
REQ-009 setpoint  input  12  unsigned target.
REQ-010 meas  input  12  unsigned ADC measurement, stable around PWM_synch.
REQ-011 clr_fault  input  1  one-cycle pulse that clears a latched fault.
REQ-012 duty  output  11  registered duty command to the PWM stage.
REQ-013 duty_vld  output  1  one-cycle pulse on the cycle duty changes.
REQ-014 fault  output  1  latched over-current shutdown flag.

Function
REQ-015 FSM states: IDLE, CAPTURE, INTEG, SUM, UPDATE, FAULT.
REQ-016 IDLE -> CAPTURE on PWM_synch & en & !fault; setpoint/meas registered on that edge.
REQ-017 CAPTURE: err = setpoint - meas (13-bit signed), saturated to [-2047, +2047].
REQ-018 INTEG: integ = integ + err, saturated to 16-bit signed [-32768, 32767].
REQ-019 SUM: s = (err >>> KP_SHIFT) + (integ >>> KI_SHIFT), clamped to [DUTY_MIN=0, DUTY_MAX=1855].
REQ-020 UPDATE: duty <= s; duty_vld = 1 for this cycle only; -> IDLE.
REQ-021 Latency: duty and duty_vld change exactly 4 clocks after the PWM_synch cycle.
REQ-022 DUTY_MAX = 1855 keeps 64 + duty + 128 <= 2047, so the downstream blanking windows never wrap.
REQ-023 PWM_synch outside IDLE is ignored, with no queuing.
REQ-024 en low in any non-FAULT state: next cycle -> IDLE, duty <= 0, integ <= 0, no duty_vld.
REQ-025 setpoint/meas changes after the capture edge do not affect the current update.

Reset
REQ-026 rst_n low asynchronously sets state = IDLE, duty = 0, duty_vld = 0, fault = 0, integ = 0, and clears the over-current monitor flags.
REQ-027 Reset mid-update aborts it; first update after release needs a fresh PWM_synch.

Configuration
REQ-028 Macro OVR_I_SHUTDOWN_EN compiled in: per-period flag sets on any cycle with ovr_I & !ovr_I_blank; evaluated and cleared at each PWM_synch.
REQ-029 With OVR_I_SHUTDOWN_EN: flag set in 2 consecutive periods -> FAULT.
- FAULT entered from any state.
- On entry: fault = 1, duty <= 0, integ <= 0, duty_vld pulses if duty was nonzero.
REQ-030 With OVR_I_SHUTDOWN_EN: FAULT -> IDLE on clr_fault, fault <= 0.
- A new fault condition in the same cycle as clr_fault wins; fault stays 1.
REQ-031 Without OVR_I_SHUTDOWN_EN: ovr_I and ovr_I_blank are unused, fault is tied 0, FAULT is unreachable.

Structure
REQ-032 Package pi_duty_ctrl_pkg holds:
- state enum;
- DUTY_MIN and DUTY_MAX;
- ERR_MAX = 2047;
- integrator width 16;
- saturation limits.
REQ-033 One sub-module, ovr_i_mon, holds the per-period flag, the consecutive-period detection and the fault latch; it is instantiated only under OVR_I_SHUTDOWN_EN.

Verification
REQ-034 Matched input: setpoint = 1000, meas = 1000 from reset, one PWM_synch -> duty = 0, duty_vld 4 clocks later.
REQ-035 Positive error: setpoint = 1200, meas = 1000 -> 1st update duty = 62 (50 + 12); 2nd update duty = 75 (integ = 400).
REQ-036 Saturation: setpoint = 4095, meas = 0 for 20 periods -> err clamps 2047, integ stops at 32767, duty = 1855; reverse (setpoint = 0, meas = 4095) -> duty = 0.
REQ-037 Mid-update behaviour:
- en dropped 2 clocks after PWM_synch -> no duty_vld, duty = 0, integ = 0.
- Extra PWM_synch during SUM -> ignored.
REQ-038 OVR_I_SHUTDOWN_EN compiled in:
- ovr_I high only while ovr_I_blank high -> no fault.
- Unblanked ovr_I in two consecutive periods -> fault = 1, duty = 0 at the second PWM_synch.
- Fault stays latched until clr_fault; clr_fault coincident with the fault condition -> fault stays 1.
